// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive path
//
// Holds the receive FSM state encoding, the parity type constants and the
// default word width used by uart_rx_ctrl and uart_rx_sampler.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - mid-bit sampler for the oversampled UART RX line
//
// Ports:
//   CLK, RST     oversampling clock, asynchronous active-low reset
//   edge_cnt     position inside the current bit (0..Prescale-1)
//   Prescale     oversampling ratio (8, 16 or 32)
//   RX_IN        synchronized serial line
//   sampled_bit  registered bit value for the current bit period
//   sample_done  one-cycle strobe in the first cycle sampled_bit is valid
//
// Build option UART_RX_MAJORITY_VOTE_EN:
//   defined   - majority of samples at Prescale/2-1, /2, /2+1; valid from /2+2
//   undefined - single sample at Prescale/2; valid from /2+1
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               RX_IN,
  output logic               sampled_bit,
  output logic               sample_done
);

  logic [PRESC_W-1:0] half;

  assign half = Prescale >> 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic samp_a;
  logic samp_b;
  logic majority;

  // The third sample is taken straight from the line in the voting cycle.
  assign majority = (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      sampled_bit <= 1'b1;
      sample_done <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      if (edge_cnt == half - PRESC_W'(1)) begin
        samp_a <= RX_IN;
      end
      if (edge_cnt == half) begin
        samp_b <= RX_IN;
      end
      if (edge_cnt == half + PRESC_W'(1)) begin
        sampled_bit <= majority;
        sample_done <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit <= 1'b1;
      sample_done <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      if (edge_cnt == half) begin
        sampled_bit <= RX_IN;
        sample_done <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: start detect, deserialize, parity/stop check
//
// Ports:
//   CLK, RST    RX oversampling clock (Prescale x baud), async active-low reset
//   RX_IN       synchronized serial line, idle high
//   Prescale    oversampling ratio (8, 16 or 32), only changed while idle
//   PAR_EN      frame carries a parity bit (latched at frame start)
//   PAR_TYP     0 even / 1 odd parity (latched at frame start)
//   P_DATA      last good received word
//   data_valid  one-cycle pulse when P_DATA updates
//   par_err     one-cycle pulse on parity mismatch
//   stp_err     one-cycle pulse when the stop bit samples low
//   busy        frame in progress
//
// Build option UART_RX_MAJORITY_VOTE_EN selects the sampling scheme inside
// uart_rx_sampler.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  rx_state_e state;
  rx_state_e next_state;

  logic [PRESC_W-1:0]    edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic                  par_bad;

  logic sampled_bit;
  logic sample_done;
  logic edge_last;
  logic last_data_bit;
  logic enter_start;
  logic enter_data;
  logic par_exp;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .edge_cnt    (edge_cnt),
    .Prescale    (Prescale),
    .RX_IN       (RX_IN),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  assign edge_last     = (edge_cnt == Prescale - PRESC_W'(1));
  assign last_data_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign enter_start   = (next_state == START) && (state != START);
  assign enter_data    = (next_state == DATA) && (state != DATA);
  assign par_exp       = (^shift_reg) ^ (par_typ_l == PAR_ODD);
  assign busy          = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          next_state = START;
        end
      end
      START: begin
        if (edge_last) begin
          next_state = sampled_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (edge_last && last_data_bit) begin
          next_state = par_en_l ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (edge_last) begin
          next_state = STOP;
        end
      end
      STOP: begin
        // A low line at the end of the stop bit is the next start bit.
        if (edge_last) begin
          next_state = RX_IN ? IDLE : START;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= PAR_EVEN;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state == IDLE || edge_last) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + PRESC_W'(1);
      end

      if (enter_data) begin
        bit_cnt <= '0;
      end else if (state == DATA && edge_last) begin
        bit_cnt <= bit_cnt + BW'(1);
      end

      if (enter_start) begin
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
        par_bad   <= 1'b0;
      end

      if (state == DATA && sample_done) begin
        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
      end

      if (state == PARITY && edge_last) begin
        par_bad <= sampled_bit ^ par_exp;
      end

      if (state == STOP && edge_last) begin
        stp_err <= ~sampled_bit;
        par_err <= par_bad;
        if (sampled_bit && !par_bad) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0, dv_n = 0, pe_n = 0, se_n = 0, busy_n = 0, dv_err_n = 0;
  int last_dv_cyc = 0, prev_dv_cyc = 0;
  int s_dv, s_pe, s_se, s_busy;

  uart_rx_ctrl #(
    .DATA_WIDTH (8),
    .PRESC_W    (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (data_valid) begin
      dv_n        <= dv_n + 1;
      prev_dv_cyc <= last_dv_cyc;
      last_dv_cyc <= cyc;
    end
    if (par_err) pe_n <= pe_n + 1;
    if (stp_err) se_n <= se_n + 1;
    if (busy) busy_n <= busy_n + 1;
    if (data_valid && (par_err || stp_err)) dv_err_n <= dv_err_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic snap();
    s_dv   = dv_n;
    s_pe   = pe_n;
    s_se   = se_n;
    s_busy = busy_n;
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    cycles(p);
  endtask

  task automatic drive_frame(input logic [7:0] d, input int p, input logic pe,
                             input logic pbit, input logic sbit);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pbit, p);
    drive_bit(sbit, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    cycles(3);
    check("rst_p_data", {24'd0, P_DATA}, 32'h0);
    check("rst_data_valid", {31'd0, data_valid}, 32'h0);
    check("rst_par_err", {31'd0, par_err}, 32'h0);
    check("rst_stp_err", {31'd0, stp_err}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    RST = 1'b1;
    cycles(4);

    // Prescale 8, even parity, 0xA5 (four ones -> parity bit 0)
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    snap();
    drive_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    cycles(6);
    check("t1_dv", dv_n - s_dv, 1);
    check("t1_pe", pe_n - s_pe, 0);
    check("t1_se", se_n - s_se, 0);
    check("t1_p_data", {24'd0, P_DATA}, 32'hA5);
    check("t1_busy_cycles", busy_n - s_busy, 88);

    // Prescale 16, odd parity, 0x3C needs parity 1, send 0
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    snap();
    drive_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
    cycles(6);
    check("t2_pe", pe_n - s_pe, 1);
    check("t2_dv", dv_n - s_dv, 0);
    check("t2_se", se_n - s_se, 0);
    check("t2_p_data", {24'd0, P_DATA}, 32'hA5);

    // Prescale 32, no parity, 0x81 with bad stop bit then good 0x55
    Prescale = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    snap();
    drive_frame(8'h81, 32, 1'b0, 1'b0, 1'b0);
    cycles(6);
    check("t3_se", se_n - s_se, 1);
    check("t3_dv", dv_n - s_dv, 0);
    check("t3_p_data_hold", {24'd0, P_DATA}, 32'hA5);
    cycles(40);
    snap();
    drive_frame(8'h55, 32, 1'b0, 1'b0, 1'b1);
    cycles(6);
    check("t3_dv2", dv_n - s_dv, 1);
    check("t3_p_data2", {24'd0, P_DATA}, 32'h55);
    check("t3_busy_cycles", busy_n - s_busy, 320);

    // Prescale 8, 3-cycle glitch
    Prescale = 6'd8;
    cycles(4);
    snap();
    drive_bit(1'b0, 3);
    RX_IN = 1'b1;
    cycles(20);
    check("t4_busy_cycles", busy_n - s_busy, 8);
    check("t4_pulses", (dv_n - s_dv) + (pe_n - s_pe) + (se_n - s_se), 0);
    check("t4_p_data", {24'd0, P_DATA}, 32'h55);

    // Back-to-back 0x12, 0x34, no parity
    snap();
    drive_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
    drive_frame(8'h34, 8, 1'b0, 1'b0, 1'b1);
    cycles(6);
    check("t5_dv", dv_n - s_dv, 2);
    check("t5_dv_spacing", last_dv_cyc - prev_dv_cyc, 80);
    check("t5_busy_cycles", busy_n - s_busy, 160);
    check("t5_p_data", {24'd0, P_DATA}, 32'h34);

    // Reset in the middle of the data bits of 0xFF
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 20);
    check("t6_busy_before", {31'd0, busy}, 32'h1);
    #3 RST = 1'b0;
    #1;
    check("t6_rst_p_data", {24'd0, P_DATA}, 32'h0);
    check("t6_rst_busy", {31'd0, busy}, 32'h0);
    check("t6_rst_flags", {29'd0, data_valid, par_err, stp_err}, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    cycles(10);
    snap();
    drive_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
    cycles(6);
    check("t6_dv", dv_n - s_dv, 1);
    check("t6_err", (pe_n - s_pe) + (se_n - s_se), 0);
    check("t6_p_data", {24'd0, P_DATA}, 32'h0F);

    check("dv_with_err", dv_err_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
